sdram_port_arb: RTL and testbench

SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

---
 rtl/sdram_port_arb.sv | 199 +++++++++++++++++++
 tb/tb_sdram_port_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arb.sv
// Two-client arbiter in front of an SDRAM core: one request in flight toward the core,
// up to MAX_OUT accepted-but-unacknowledged requests whose owners are tracked in order.
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties).
module sdram_port_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_LEN   = $clog2(DATA_WIDTH) - 2,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [WORD_LEN-1:0]   c0_wr,
    input  logic                  c0_rd,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [DATA_WIDTH-1:0] c0_write_data,
    output logic                  c0_accept,
    output logic                  c0_ack,
    output logic                  c0_error,
    output logic [DATA_WIDTH-1:0] c0_read_data,

    input  logic [WORD_LEN-1:0]   c1_wr,
    input  logic                  c1_rd,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [DATA_WIDTH-1:0] c1_write_data,
    output logic                  c1_accept,
    output logic                  c1_ack,
    output logic                  c1_error,
    output logic [DATA_WIDTH-1:0] c1_read_data,

    output logic [WORD_LEN-1:0]   m_wr,
    output logic                  m_rd,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_write_data,
    input  logic                  m_accept,
    input  logic                  m_ack,
    input  logic                  m_error,
    input  logic [DATA_WIDTH-1:0] m_read_data
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUT);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [WORD_LEN-1:0]   cl_wr    [2];
    logic [ADDR_WIDTH-1:0] cl_addr  [2];
    logic [DATA_WIDTH-1:0] cl_wdata [2];
    logic [DATA_WIDTH-1:0] rdata_vec [2];
    logic [1:0]            cl_rd;
    logic [1:0]            pending;
    logic [1:0]            accept_vec;
    logic [1:0]            ack_vec;

    logic [0:0]       state_reg, state_next;
    logic             owner_reg;
    logic             last_grant_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             fifo_mem [MAX_OUT];

    logic push, pop, head_owner, other, b2b_ok, idle_grant;
    logic load_en, load_sel, clear_en;

    assign cl_wr[0]    = c0_wr;
    assign cl_wr[1]    = c1_wr;
    assign cl_rd       = {c1_rd, c0_rd};
    assign cl_addr[0]  = c0_addr;
    assign cl_addr[1]  = c1_addr;
    assign cl_wdata[0] = c0_write_data;
    assign cl_wdata[1] = c1_write_data;

    assign push       = (state_reg == ISSUE) & m_accept;
    assign pop        = m_ack & (count_reg != '0);
    assign head_owner = fifo_mem[rd_ptr_reg];
    assign other      = ~owner_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            assign pending[gi]    = (cl_wr[gi] != '0) | cl_rd[gi];
            assign accept_vec[gi] = push & (owner_reg == 1'(gi));
            assign ack_vec[gi]    = pop & (head_owner == 1'(gi));
            assign rdata_vec[gi]  = ack_vec[gi] ? m_read_data : '0;
        end
    endgenerate

    assign c0_accept    = accept_vec[0];
    assign c1_accept    = accept_vec[1];
    assign c0_ack       = ack_vec[0];
    assign c1_ack       = ack_vec[1];
    assign c0_error     = ack_vec[0] & m_error;
    assign c1_error     = ack_vec[1] & m_error;
    assign c0_read_data = rdata_vec[0];
    assign c1_read_data = rdata_vec[1];

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        idle_grant = pending[1] & ~pending[0];
        if (pending[0] && pending[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            idle_grant = 1'b0;
`else
            idle_grant = ~last_grant_reg;
`endif
        end
    end

    // The just-accepted client is never eligible here, so only the other one can chain.
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Chain only toward client 0; after a client-0 accept, re-arbitrate so it keeps priority.
    assign b2b_ok = pending[other] & (count_next < FULL) & owner_reg;
`else
    assign b2b_ok = pending[other] & (count_next < FULL);
`endif

    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        load_sel   = 1'b0;
        clear_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((pending != 2'b00) && (count_reg < FULL)) begin
                    load_en    = 1'b1;
                    load_sel   = idle_grant;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (m_accept) begin
                    if (b2b_ok) begin
                        load_en  = 1'b1;
                        load_sel = other;
                    end else begin
                        clear_en   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            m_wr           <= '0;
            m_rd           <= 1'b0;
            m_addr         <= '0;
            m_write_data   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (load_en) begin
                m_wr           <= cl_wr[load_sel];
                m_rd           <= cl_rd[load_sel];
                m_addr         <= cl_addr[load_sel];
                m_write_data   <= cl_wdata[load_sel];
                owner_reg      <= load_sel;
                last_grant_reg <= load_sel;
            end else if (clear_en) begin
                m_wr         <= '0;
                m_rd         <= 1'b0;
                m_addr       <= '0;
                m_write_data <= '0;
            end
        end
    end

    // Owner storage needs no reset: entries are only read while count_reg says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= owner_reg;
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Scoreboard bench for sdram_port_arb: owners are recorded in order when the core accepts,
// and every core acknowledge is checked against the head owner of that reference queue.
module tb_sdram_port_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WL = $clog2(DW) - 2;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [WL-1:0] cl_wr    [2];
    logic          cl_rd    [2];
    logic [AW-1:0] cl_addr  [2];
    logic [DW-1:0] cl_wdata [2];

    logic          c0_accept, c0_ack, c0_error, c1_accept, c1_ack, c1_error;
    logic [DW-1:0] c0_read_data, c1_read_data;
    logic [WL-1:0] m_wr;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_write_data;
    logic          m_accept = 1'b0, m_ack = 1'b0, m_error = 1'b0;
    logic [DW-1:0] m_read_data = '0;

    sdram_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .MAX_OUT(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_wr(cl_wr[0]), .c0_rd(cl_rd[0]), .c0_addr(cl_addr[0]), .c0_write_data(cl_wdata[0]),
        .c0_accept(c0_accept), .c0_ack(c0_ack), .c0_error(c0_error), .c0_read_data(c0_read_data),
        .c1_wr(cl_wr[1]), .c1_rd(cl_rd[1]), .c1_addr(cl_addr[1]), .c1_write_data(cl_wdata[1]),
        .c1_accept(c1_accept), .c1_ack(c1_ack), .c1_error(c1_error), .c1_read_data(c1_read_data),
        .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_write_data(m_write_data),
        .m_accept(m_accept), .m_ack(m_ack), .m_error(m_error), .m_read_data(m_read_data)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int glog[$];
    bit log_en = 1'b0;
    logic [1:0] acc_seen = 2'b00;
    int cmode[2];
    int acc_mode = 0;
    int ack_mode = 0;
    int unsigned seq = 0;
    int acc_cnt0 = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cl_act(int n);
        return (cl_wr[n] != '0) || cl_rd[n];
    endfunction

    function automatic bit m_act();
        return (m_wr != '0) || m_rd;
    endfunction

    task automatic new_req(int n);
        seq++;
        if ($urandom_range(0, 1) == 1) begin
            cl_rd[n] = 1'b1;
            cl_wr[n] = '0;
        end else begin
            cl_rd[n] = 1'b0;
            cl_wr[n] = WL'($urandom_range(1, (1 << WL) - 1));
        end
        // Top address bit tags the client so each pending request is uniquely identifiable.
        cl_addr[n]  = AW'(seq) | (AW'(n) << (AW - 1));
        cl_wdata[n] = $urandom;
    endtask

    task automatic drop_req(int n);
        cl_wr[n] = '0;
        cl_rd[n] = 1'b0;
        cl_addr[n] = '0;
        cl_wdata[n] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            bit active;
            active = cl_act(n);
            case (cmode[n])
                1: if (acc_seen[n] || !active) new_req(n);
                2: if (acc_seen[n] || !active) begin
                       if ($urandom_range(0, 1) == 1) new_req(n);
                       else drop_req(n);
                   end
                default: if (acc_seen[n]) drop_req(n);
            endcase
        end
        m_accept    = (acc_mode == 1) ? 1'b1 : (acc_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        m_ack       = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? ($urandom_range(0, 9) < 4) : 1'b0;
        m_error     = ($urandom_range(0, 3) == 0);
        m_read_data = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_req(0);
        drop_req(1);
        cmode[0] = 0;
        cmode[1] = 0;
        acc_mode = 0;
        ack_mode = 0;
        m_accept = 1'b0;
        m_ack = 1'b0;
        m_error = 1'b0;
        m_read_data = '0;
        exp_q.delete();
        acc_cnt0 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_req", {m_wr, m_rd, m_addr, m_write_data}, 0);
        check("rst_client_out", {c0_accept, c0_ack, c0_error, c0_read_data,
                                 c1_accept, c1_ack, c1_error, c1_read_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_active(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_act()) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic issue_one(int n);
        new_req(n);
        wait_active("issue_timeout");
        m_accept = 1'b1;
        tick();
    endtask

    // Monitor: responses pop the reference owner queue, accepts push onto it.
    int mon_own;
    int mon_head;
    logic [1:0] mon_acc;
    logic [DW+1:0] exp_r0, exp_r1;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_seen = 2'b00;
        end else begin
            mon_head = -1;
            if (m_ack && exp_q.size() > 0) begin
                mon_head = exp_q.pop_front();
                $display("ack: client %0d data %h error %0b", mon_head, m_read_data, m_error);
            end
            exp_r0 = (mon_head == 0) ? {1'b1, m_error, m_read_data} : '0;
            exp_r1 = (mon_head == 1) ? {1'b1, m_error, m_read_data} : '0;
            check("resp_c0", {c0_ack, c0_error, c0_read_data}, exp_r0);
            check("resp_c1", {c1_ack, c1_error, c1_read_data}, exp_r1);

            mon_acc = 2'b00;
            acc_seen = 2'b00;
            if (m_accept && m_act()) begin
                mon_own = -1;
                for (int n = 0; n < 2; n++) begin
                    if (mon_own < 0 && cl_act(n) && cl_addr[n] == m_addr) mon_own = n;
                end
                if (mon_own < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_req_owner: m_addr %h matches no pending client request", m_addr);
                end else begin
                    mon_acc[mon_own] = 1'b1;
                    acc_seen[mon_own] = 1'b1;
                    exp_q.push_back(mon_own);
                    if (log_en) glog.push_back(mon_own);
                    check("m_req_fields", {m_wr, m_rd, m_write_data},
                          {cl_wr[mon_own], cl_rd[mon_own], cl_wdata[mon_own]});
                end
            end
            check("accept", {c1_accept, c0_accept}, mon_acc);
            acc_cnt0 += int'(c0_accept);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int expg;

        // Single read from client 0, accepted two cycles after m_rd rises.
        do_reset();
        cl_rd[0] = 1'b1;
        cl_addr[0] = AW'(32'h100);
        wait_active("a_m_rd_rise");
        check("a_m_addr", m_addr, 32'h100);
        tick();
        m_accept = 1'b1;
        tick();
        check("a_m_rd_cleared", {m_wr, m_rd}, 0);
        tick();
        check("a_accept_pulses", acc_cnt0, 1);
        m_ack = 1'b1;
        m_error = 1'b0;
        m_read_data = 32'hDEADBEEF;
        @(negedge clk);
        #1;
        check("a_c0_ack", {c0_ack, c0_error, c0_read_data}, {2'b10, 32'hDEADBEEF});
        check("a_c1_ack", {c1_ack, c1_read_data}, 0);
        tick();

        // Both clients streaming, core always accepting and acknowledging.
        do_reset();
        glog.delete();
        log_en = 1'b1;
        cmode[0] = 1;
        cmode[1] = 1;
        acc_mode = 1;
        ack_mode = 1;
        repeat (20) tick();
        log_en = 1'b0;
        check("b_grant_count", glog.size() >= 8, 1);
        for (int k = 0; k < glog.size(); k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            expg = 0;
`else
            expg = k % 2;
`endif
            check("b_grant_seq", glog[k], expg);
        end
        cmode[0] = 0;
        cmode[1] = 0;
        repeat (10) tick();

        // Fill the owner FIFO with no acknowledges; nothing may issue until a pop.
        do_reset();
        cmode[0] = 1;
        acc_mode = 1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (exp_q.size() == MO) begin
                ok = 1'b1;
                break;
            end
        end
        check("c_fill", ok, 1);
        new_req(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c_full_stall", {m_wr, m_rd}, 0);
        end
        m_ack = 1'b1;
        wait_active("c_resume");
        cmode[0] = 0;
        ack_mode = 1;
        repeat (20) tick();

        // Owners 0,1,1 then three acknowledges, the second one with error.
        do_reset();
        issue_one(0);
        issue_one(1);
        issue_one(1);
        for (int k = 0; k < 3; k++) begin
            tick();
            m_ack = 1'b1;
            m_error = (k == 1);
            @(negedge clk);
            #1;
            check("d_c0_ack_err", {c0_ack, c0_error}, (k == 0) ? 2'b10 : 2'b00);
            check("d_c1_ack_err", {c1_ack, c1_error}, (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : 2'b10);
        end
        tick();

        // Push and pop in the same cycle, then ack with an empty FIFO, then reset mid-issue.
        do_reset();
        issue_one(0);
        issue_one(1);
        new_req(0);
        wait_active("e_third_issue");
        m_accept = 1'b1;
        m_ack = 1'b1;
        m_error = 1'b0;
        @(negedge clk);
        #1;
        check("e_same_cycle_ack", {c0_ack, c1_ack}, 2'b10);
        for (int k = 0; k < 3; k++) begin
            tick();
            m_ack = 1'b1;
            @(negedge clk);
            #1;
            check("e_drain_ack", {c0_ack, c1_ack}, (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00);
        end
        tick();
        new_req(1);
        wait_active("e_reset_issue");
        m_accept = 1'b1;
        rst_n = 1'b0;
        #1;
        check("e_rst_m_req", {m_wr, m_rd, m_addr, m_write_data}, 0);
        check("e_rst_accept", {c0_accept, c1_accept}, 0);

        // Randomized traffic against the owner-queue reference.
        do_reset();
        cmode[0] = 2;
        cmode[1] = 2;
        acc_mode = 2;
        ack_mode = 2;
        repeat (1500) tick();
        cmode[0] = 0;
        cmode[1] = 0;
        acc_mode = 1;
        ack_mode = 1;
        repeat (30) tick();
        acc_mode = 0;
        ack_mode = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
